// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter.
// Package name is arb_pkg; imported by the interface, rr_pick and rr_arbiter_4.
// Optional hold timeout is enabled by defining RR_ARB_TIMEOUT_EN (see rr_arbiter_4).
package arb_pkg;

    // Requester count is fixed at four; pointer needs two bits to index it.
    localparam int N_REQ = 4;
    localparam int PTR_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef logic [N_REQ-1:0] req_vec_t;

    // Convert a one-hot grant back into the requester index it names.
    // A zero vector maps to index 0; callers only use it on a live grant.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input req_vec_t vec);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters and rr_arbiter_4.
// The master side owns req_i/done_i; the slave side (the arbiter) owns the grant.
interface rr_arbiter_4_if;
    import arb_pkg::*;

    req_vec_t req_i;
    logic     done_i;
    req_vec_t grant_o;
    logic     grant_valid_o;
    logic     timeout_o;

    modport master (
        output req_i,
        output done_i,
        input  grant_o,
        input  grant_valid_o,
        input  timeout_o
    );

    modport slave (
        input  req_i,
        input  done_i,
        output grant_o,
        output grant_valid_o,
        output timeout_o
    );

endinterface

// File: rtl/rr_arbiter_4_pick.sv
// Combinational round-robin winner selection.
// The request vector is rotated so the requester after last_ptr sits at bit 0,
// the lowest set bit is isolated, and the result is rotated back into place.
// The output is one-hot, or zero when no request is present.
module rr_pick
    import arb_pkg::*;
(
    input  req_vec_t               req,
    input  logic     [PTR_W-1:0]   last_ptr,
    output req_vec_t               winner
);

    logic [PTR_W-1:0] start;
    req_vec_t         rotated;
    req_vec_t         rot_pick;

    // Rotate, keep the lowest set bit (x & -x), rotate back.
    always_comb begin
        start    = last_ptr + 1'b1;
        rotated  = '0;
        winner   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rotated[i] = req[start + PTR_W'(i)];
        end
        rot_pick = rotated & ((~rotated) + req_vec_t'(1));
        for (int i = 0; i < N_REQ; i++) begin
            winner[start + PTR_W'(i)] = rot_pick[i];
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with a registered one-hot grant.
// A grant is held until the owner raises done_i or drops its request; every
// release costs one idle bubble before the next arbitration.
// Define RR_ARB_TIMEOUT_EN to add a hold counter that forces release after
// HOLD_MAX cycles and pulses timeout_o; otherwise timeout_o is tied low.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
)
(
    input  logic            clk,
    input  logic            rst_n,
    rr_arbiter_4_if.slave   bus
);

    if (HOLD_MAX < 2) begin : g_bad_hold_max
        $error("rr_arbiter_4: HOLD_MAX must be at least 2");
    end

    state_t            state_q;
    state_t            state_d;
    logic [PTR_W-1:0]  last_ptr_q;
    logic [PTR_W-1:0]  last_ptr_d;
    req_vec_t          grant_q;
    req_vec_t          grant_d;
    req_vec_t          winner;
    logic              owner_release;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             timeout_q;
    logic             timeout_d;
`endif

    rr_pick u_pick (
        .req      (bus.req_i),
        .last_ptr (last_ptr_q),
        .winner   (winner)
    );

    // The owner releases by finishing or by dropping its own request line;
    // both together still count as a single release.
    assign owner_release = bus.done_i || ((grant_q & bus.req_i) == '0);

    // Next-state and next-grant decisions for the IDLE/GRANT controller.
    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        grant_d    = grant_q;
`ifdef RR_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (bus.req_i != '0) begin
                    grant_d = winner;
                    state_d = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                if (owner_release) begin
                    grant_d    = '0;
                    last_ptr_d = onehot_to_idx(grant_q);
                    state_d    = IDLE;
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (hold_cnt_q == HOLD_LAST) begin
                    grant_d    = '0;
                    last_ptr_d = onehot_to_idx(grant_q);
                    state_d    = IDLE;
                    timeout_d  = 1'b1;
                end
                else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and grant registers; reset makes requester 0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_ptr_q <= PTR_W'(N_REQ - 1);
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            grant_q    <= grant_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Hold counter and the registered one-cycle timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.grant_o       = grant_q;
    assign bus.grant_valid_o = |grant_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios followed by a
// randomized run compared against a requester-level round-robin model.
module tb_rr_arbiter_4;

    localparam int HOLD_MAX = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    rr_arbiter_4_if bus ();

    rr_arbiter_4 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the bus, who was served last, how long held.
    bit         m_busy;
    int         m_owner;
    int         m_last;
    int         m_held;
    logic [3:0] m_grant;
    logic       m_timeout;

    task automatic model_reset();
        m_busy    = 1'b0;
        m_owner   = 0;
        m_last    = 3;
        m_held    = 0;
        m_grant   = 4'b0000;
        m_timeout = 1'b0;
    endtask

    task automatic model_update(input logic [3:0] r, input logic d);
        m_timeout = 1'b0;
        if (m_busy) begin
            if (d || !r[m_owner]) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end else if (TIMEOUT_ON && m_held == HOLD_MAX - 1) begin
                m_busy    = 1'b0;
                m_last    = m_owner;
                m_timeout = 1'b1;
            end else begin
                m_held++;
            end
        end else if (r != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (r[c]) begin
                    m_owner = c;
                    m_busy  = 1'b1;
                    m_held  = 0;
                    break;
                end
            end
        end
        m_grant = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    endtask

    // Advance one clock; DUT and model see the same sampled inputs.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_update(bus.req_i, bus.done_i);
        #1;
    endtask

    // The grant must never carry more than one bit.
    always @(negedge clk) begin
        vectors++;
        if (!$onehot0(bus.grant_o)) begin
            miscompares++;
            $display("[TB] FAIL onehot0 grant=%b", bus.grant_o);
        end
    end

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.req_i  = 4'b1111;
        bus.done_i = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (bus.grant_o !== 4'b0000 || bus.grant_valid_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold got grant=%b valid=%b to=%b want 0000/0/0",
                         bus.grant_o, bus.grant_valid_o, bus.timeout_o);
            end
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (bus.grant_o !== 4'b0001 || bus.grant_valid_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_first_grant got %b valid=%b want 0001/1", bus.grant_o, bus.grant_valid_o);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] expected [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if (bus.grant_o !== m_grant || bus.grant_o === 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL rotation_hold[%0d] got %b want %b", k, bus.grant_o, m_grant);
            end
            bus.done_i = 1'b1;
            step();
            bus.done_i = 1'b0;
            vectors++;
            if (bus.grant_o !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL rotation_bubble[%0d] got %b want 0000", k, bus.grant_o);
            end
            step();
            vectors++;
            if (bus.grant_o !== expected[k]) begin
                miscompares++;
                $display("[TB] FAIL rotation_next[%0d] got %b want %b", k, bus.grant_o, expected[k]);
            end
        end
    endtask

    task automatic test_single();
        bus.req_i = 4'b0100;
        step();
        step();
        vectors++;
        if (bus.grant_o !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL single_grant got %b want 0100", bus.grant_o);
        end
        bus.req_i = 4'b0000;
        step();
        vectors++;
        if (bus.grant_o !== 4'b0000 || bus.grant_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_drop got %b valid=%b want 0000/0", bus.grant_o, bus.grant_valid_o);
        end
        bus.req_i = 4'b1100;
        step();
        vectors++;
        if (bus.grant_o !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL single_pointer got %b want 1000", bus.grant_o);
        end
    endtask

    task automatic test_simultaneous();
        bus.req_i = 4'b0011;
        step();
        step();
        vectors++;
        if (bus.grant_o !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL simul_setup got %b want 0001", bus.grant_o);
        end
        bus.req_i  = 4'b0010;
        bus.done_i = 1'b1;
        step();
        bus.done_i = 1'b0;
        bus.req_i  = 4'b0011;
        vectors++;
        if (bus.grant_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL simul_release got %b want 0000", bus.grant_o);
        end
        step();
        vectors++;
        if (bus.grant_o !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL simul_next got %b want 0010", bus.grant_o);
        end
    endtask

    task automatic test_async_reset();
        bus.req_i  = 4'b0100;
        bus.done_i = 1'b1;
        step();
        bus.done_i = 1'b0;
        step();
        vectors++;
        if (bus.grant_o !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL async_setup got %b want 0100", bus.grant_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (bus.grant_o !== 4'b0000 || bus.grant_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_clear got %b valid=%b want 0000/0", bus.grant_o, bus.grant_valid_o);
        end
        bus.req_i = 4'b1111;
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (bus.grant_o !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL async_regrant got %b want 0001", bus.grant_o);
        end
    endtask

    task automatic test_hold_limit();
        rst_n      = 1'b0;
        bus.req_i  = 4'b0011;
        bus.done_i = 1'b0;
        step();
        rst_n = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < HOLD_MAX; i++) begin
            step();
            vectors++;
            if (bus.grant_o !== 4'b0001 || bus.timeout_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL timeout_hold[%0d] got %b to=%b want 0001/0", i, bus.grant_o, bus.timeout_o);
            end
        end
        step();
        vectors++;
        if (bus.grant_o !== 4'b0000 || bus.timeout_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_pulse got %b to=%b want 0000/1", bus.grant_o, bus.timeout_o);
        end
        step();
        vectors++;
        if (bus.grant_o !== 4'b0010 || bus.timeout_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_next got %b to=%b want 0010/0", bus.grant_o, bus.timeout_o);
        end
`else
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (bus.grant_o !== 4'b0001 || bus.timeout_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hold_forever[%0d] got %b to=%b want 0001/0", i, bus.grant_o, bus.timeout_o);
            end
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req_i = 4'($urandom_range(0, 15));
            bus.done_i = ($urandom_range(0, 7) == 0);
            step();
            vectors++;
            if (bus.grant_o !== m_grant || bus.grant_valid_o !== (m_grant != 4'b0000) ||
                bus.timeout_o !== m_timeout) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] got %b/%b/%b want %b/%b/%b", i,
                         bus.grant_o, bus.grant_valid_o, bus.timeout_o,
                         m_grant, (m_grant != 4'b0000), m_timeout);
            end
        end
        bus.done_i = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.req_i   = 4'b0000;
        bus.done_i  = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_rotation();
        test_single();
        test_simultaneous();
        test_async_reset();
        test_hold_limit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
